// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - RV32I fetch stage with IF/ID register and one-entry hold buffer.
// Define IF_PERF_CNT_EN to add the fetch_cnt/bubble_cnt performance counters.
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus_out,
   output logic [31:0] ir_out,
   output logic        valid_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] bubble_cnt
`endif
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_q;
   logic [31:0] pc_nxt;
   logic [31:0] pc_inc;
   logic        buf_full;
   logic [31:0] buf_pc;
   logic [31:0] buf_ir;
   logic        req_raw;
   logic        deliver;
   logic        capture;

   assign pc_inc = pc_q + 32'd4;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: if (!flush && !buf_full) state_nxt = S_WAIT;
         S_WAIT: begin
            if (imem_rvalid) begin
               if (flush || stall) state_nxt = S_FETCH;
            end else if (flush) begin
               state_nxt = S_DROP;
            end
         end
         S_DROP:  if (imem_rvalid) state_nxt = S_FETCH;
         default: state_nxt = S_FETCH;
      endcase
   end

   // A response arriving unstalled immediately chains the next request (1 insn/cycle).
   always_comb begin
      req_raw   = 1'b0;
      imem_addr = pc_q;
      deliver   = 1'b0;
      capture   = 1'b0;
      case (state)
         S_FETCH: req_raw = !flush && !buf_full;
         S_WAIT: begin
            if (imem_rvalid && !flush) begin
               if (stall) begin
                  capture = 1'b1;
               end else begin
                  deliver   = 1'b1;
                  req_raw   = 1'b1;
                  imem_addr = pc_inc;
               end
            end
         end
         default: ;
      endcase
   end

   // Reset state is FETCH, so mask the request while reset is held.
   assign imem_req = req_raw & rstn;

   always_comb begin
      pc_nxt = pc_q;
      if (flush)                             pc_nxt = redirect_pc;
      else if (state == S_WAIT && imem_rvalid) pc_nxt = pc_inc;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) pc_q <= RESET_PC;
      else       pc_q <= pc_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buf_full <= 1'b0;
         buf_pc   <= 32'd0;
         buf_ir   <= 32'd0;
      end else if (flush) begin
         buf_full <= 1'b0;
      end else if (capture) begin
         buf_full <= 1'b1;
         buf_pc   <= pc_q;
         buf_ir   <= imem_rdata;
      end else if (!stall && buf_full) begin
         buf_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_out      <= 32'd0;
         pc_plus_out <= 32'd0;
         ir_out      <= NOP_INSN;
         valid_out   <= 1'b0;
      end else if (flush) begin
         pc_out      <= 32'd0;
         pc_plus_out <= 32'd0;
         ir_out      <= NOP_INSN;
         valid_out   <= 1'b0;
      end else if (!stall) begin
         if (buf_full) begin
            pc_out      <= buf_pc;
            pc_plus_out <= buf_pc + 32'd4;
            ir_out      <= buf_ir;
            valid_out   <= 1'b1;
         end else if (deliver) begin
            pc_out      <= pc_q;
            pc_plus_out <= pc_inc;
            ir_out      <= imem_rdata;
            valid_out   <= 1'b1;
         end else begin
            pc_out      <= 32'd0;
            pc_plus_out <= 32'd0;
            ir_out      <= NOP_INSN;
            valid_out   <= 1'b0;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   logic load_insn;
   logic load_bubble;

   assign load_insn   = !flush && !stall && (buf_full || deliver);
   assign load_bubble = flush || (!stall && !buf_full && !deliver);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_cnt  <= 32'd0;
         bubble_cnt <= 32'd0;
      end else begin
         if (load_insn)   fetch_cnt  <= fetch_cnt + 32'd1;
         if (load_bubble) bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed vector bench for if_id_stage with a variable-latency memory model.
// Memory returns addr ^ 32'hA5A5_0000 after lat cycles.
module tb_if_id_stage;

   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] pc_plus_out;
   logic [31:0] ir_out;
   logic        valid_out;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int lat    = 1;

   always #5 clk = ~clk;

   if_id_stage dut (
      .clk         (clk),
      .rstn        (rstn),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc_out      (pc_out),
      .pc_plus_out (pc_plus_out),
      .ir_out      (ir_out),
      .valid_out   (valid_out)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt),
      .bubble_cnt  (bubble_cnt)
`endif
   );

   // Memory responder: single outstanding request, forgets everything on reset.
   logic        m_pend;
   int          m_cnt;
   logic [31:0] m_addr;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_pend      <= 1'b0;
         m_cnt       <= 0;
         m_addr      <= 32'd0;
         imem_rvalid <= 1'b0;
         imem_rdata  <= 32'd0;
      end else begin
         imem_rvalid <= 1'b0;
         if (m_pend) begin
            if (m_cnt == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= m_addr ^ K;
               m_pend      <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
         if (imem_req) begin
            if (lat == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= imem_addr ^ K;
            end else begin
               m_pend <= 1'b1;
               m_addr <= imem_addr;
               m_cnt  <= lat - 1;
            end
         end
      end
   end

   typedef struct {
      logic        stall;
      logic        flush;
      logic [31:0] redir;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_ir;
   } vec_t;

   vec_t tv[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic f, input logic [31:0] r);
      @(negedge clk);
      stall       = s;
      flush       = f;
      redirect_pc = r;
      #1;
   endtask

   task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_ir);
      chk($sformatf("%s imem_req", tag), {31'd0, imem_req}, {31'd0, e_req});
      if (e_req) chk($sformatf("%s imem_addr", tag), imem_addr, e_addr);
      chk($sformatf("%s valid_out", tag), {31'd0, valid_out}, {31'd0, e_valid});
      chk($sformatf("%s pc_out", tag), pc_out, e_pc);
      chk($sformatf("%s pc_plus_out", tag), pc_plus_out, e_valid ? e_pc + 32'd4 : 32'd0);
      chk($sformatf("%s ir_out", tag), ir_out, e_ir);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 rstn = 1'b1;
   endtask

   initial begin
      rstn = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;

      //                stl   fl    redir        req   addr         v     pc           ir
      tv[0]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0,       NOP};
      tv[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h4,       1'b0, 32'h0,       NOP};
      tv[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h8,       1'b1, 32'h0,       K};
      tv[3]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'hC,       1'b1, 32'h4,       K | 32'h4};
      tv[4]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h8,       K | 32'h8};
      tv[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h8,       K | 32'h8};
      tv[6]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h8,       K | 32'h8};
      tv[7]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h8,       K | 32'h8};
      tv[8]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h10,      1'b1, 32'hC,       K | 32'hC};
      tv[9]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h14,      1'b0, 32'h0,       NOP};
      tv[10] = '{1'b0, 1'b1, 32'h100,     1'b0, 32'h0,       1'b1, 32'h10,      K | 32'h10};
      tv[11] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h100,     1'b0, 32'h0,       NOP};
      tv[12] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h104,     1'b0, 32'h0,       NOP};
      tv[13] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h108,     1'b1, 32'h100,     K | 32'h100};
      tv[14] = '{1'b1, 1'b1, 32'h300,     1'b0, 32'h0,       1'b1, 32'h104,     K | 32'h104};
      tv[15] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h300,     1'b0, 32'h0,       NOP};
      tv[16] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h304,     1'b0, 32'h0,       NOP};
      tv[17] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h308,     1'b1, 32'h300,     K | 32'h300};

      repeat (3) @(negedge clk);
      #1 check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      release_reset();
      for (int i = 0; i < 18; i++) begin
         drive(tv[i].stall, tv[i].flush, tv[i].redir);
         check_out($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_valid, tv[i].e_pc, tv[i].e_ir);
      end

      // 3-cycle memory, flush one cycle after the request: stale response dropped.
      drive(1'b0, 1'b0, 32'h0);
      rstn = 1'b0;
      lat  = 3;
      repeat (2) @(negedge clk);
      release_reset();
      drive(1'b0, 1'b0, 32'h0);     check_out("drop c0", 1'b1, 32'h0,   1'b0, 32'h0, NOP);
      drive(1'b0, 1'b1, 32'h200);   check_out("drop c1", 1'b0, 32'h0,   1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);     check_out("drop c2", 1'b0, 32'h0,   1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);     check_out("drop c3", 1'b0, 32'h0,   1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);     check_out("drop c4", 1'b1, 32'h200, 1'b0, 32'h0, NOP);
      for (int c = 5; c < 7; c++) begin
         drive(1'b0, 1'b0, 32'h0);  check_out($sformatf("drop c%0d", c), 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      end
      drive(1'b0, 1'b0, 32'h0);     check_out("drop c7", 1'b1, 32'h204, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);     check_out("drop c8", 1'b0, 32'h0,   1'b1, 32'h200, K | 32'h200);

      // Reset mid-request, restart at RESET_PC, then redirect to the top of the address space.
      rstn = 1'b0;
      lat  = 1;
      repeat (2) @(negedge clk);
      release_reset();
      drive(1'b0, 1'b0, 32'h0);     check_out("rst c0", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);     check_out("rst c1", 1'b1, 32'h4, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);     check_out("rst c2", 1'b1, 32'h8, 1'b1, 32'h0, K);
      drive(1'b0, 1'b0, 32'h0);     check_out("rst c3", 1'b1, 32'hC, 1'b1, 32'h4, K | 32'h4);
      rstn = 1'b0;
      #1 check_out("async rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt after reset", fetch_cnt, 32'd0);
      chk("bubble_cnt after reset", bubble_cnt, 32'd0);
`endif
      repeat (2) @(negedge clk);
      release_reset();
      drive(1'b0, 1'b0, 32'h0);         check_out("wrap c0", 1'b1, 32'h0,         1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);         check_out("wrap c1", 1'b1, 32'h4,         1'b0, 32'h0, NOP);
      drive(1'b0, 1'b1, 32'hFFFF_FFFC); check_out("wrap c2", 1'b0, 32'h0,         1'b1, 32'h0, K);
      drive(1'b0, 1'b0, 32'h0);         check_out("wrap c3", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);         check_out("wrap c4", 1'b1, 32'h0,         1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0);         check_out("wrap c5", 1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
      chk("wrap pc_plus_out", pc_plus_out, 32'h0);
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt count", fetch_cnt, 32'd2);
      chk("bubble_cnt count", bubble_cnt, 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core. It owns the PC and issues single-outstanding fetches to the instruction memory. It absorbs variable memory latency with a one-entry hold buffer. It presents pc, pc+4 and instruction to the decode stage, which feeds ID_EX. Stall comes from the hazard unit (load-use); flush/redirect comes from EX on a taken branch or jump.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INSN, 32'h0000_0013, instruction word inserted on bubble/flush (addi x0,x0,0).
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- stall  in  1  hold IF/ID outputs and PC; from hazard unit.
- flush  in  1  taken branch/jump in EX; kill in-flight fetch and IF/ID contents.
- redirect_pc  in  32  target PC, valid while flush=1.
- imem_req  out  1  fetch request; always accepted in the cycle it is asserted.
- imem_addr  out  32  fetch address, valid while imem_req=1.
- imem_rvalid  in  1  response valid, ≥1 cycle after request.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- pc_out  out  32  PC of instruction in ID.
- pc_plus_out  out  32  pc_out+4.
- ir_out  out  32  instruction in ID.
- valid_out  out  1  ID slot holds a real instruction.

## Operation
- FSM states: FETCH (may issue), WAIT (request outstanding), DROP (outstanding response is stale).
- FETCH: if flush, pc_q<=redirect_pc, no request, stay FETCH. Else if hold buffer full, no request. Else imem_req=1, imem_addr=pc_q, go to WAIT.
- WAIT, imem_rvalid=1:
  - with flush: discard rdata; pc_q<=redirect_pc; go to FETCH.
  - without stall: deliver into IF/ID (pc_q, pc_q+4, rdata, valid=1); pc_q<=pc_q+4; same cycle issue imem_req=1, imem_addr=pc_q+4; stay WAIT (back-to-back).
  - with stall: capture {pc_q, rdata} into hold buffer; pc_q<=pc_q+4; go to FETCH.
- WAIT, no rvalid: with flush, pc_q<=redirect_pc, go to DROP; else stay.
- DROP: on imem_rvalid, discard and go to FETCH. A flush in DROP overwrites pc_q with redirect_pc and stays in DROP.
- IF/ID register update priority:
  1. flush: valid 0, ir NOP_INSN, pc/pc_plus 0; hold buffer cleared.
  2. stall: hold all outputs.
  3. hold buffer full: load from buffer; clear buffer.
  4. delivery this cycle: load delivered word.
  5. otherwise bubble: valid 0, ir NOP_INSN, pc/pc_plus 0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. Low two bits of the PC are not checked.
- Never more than one outstanding request. imem_rvalid outside WAIT/DROP is ignored.

## Timing
- Reset (async, rstn=0): pc_q=RESET_PC, state FETCH, buffer empty, imem_req=0, pc_out=0, pc_plus_out=0, ir_out=NOP_INSN, valid_out=0.
- First imem_req is asserted in the first cycle after rstn deasserts, with imem_addr=RESET_PC.
- Latency for a 1-cycle memory: request issued in cycle n, rvalid in n+1, valid_out=1 from n+2. Steady-state throughput is 1 instruction/cycle.
- Flush in cycle n: valid_out=0 in n+1. The first fetch of redirect_pc is issued in n+1 (from FETCH or WAIT-with-rvalid) or after the stale response (from DROP).
- Stall and flush in the same cycle: flush wins.
- rstn asserted mid-request: the response is lost; the memory must not return rvalid for requests issued before reset.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each delivered (non-discarded) instruction.
  - bubble_cnt increments each cycle IF/ID loads a bubble (rules 1 or 5).
  - Both counters wrap at 2^32.
- IF_PERF_CNT_EN undefined: counters and ports are absent; behaviour is otherwise identical.

## Test plan
- Reset release, 1-cycle memory returning addr^32'hA5A5_0000: valid_out first 1 two cycles after release with pc_out=0, ir_out=32'hA5A5_0000; pc_out steps 0,4,8 on consecutive cycles.
- stall=1 for 3 cycles at pc_out=8: pc_out/ir_out hold for 3 cycles; the word for 12 is captured in the buffer; no imem_req while the buffer is full; pc_out=12 the cycle after stall drops, with no duplicate or skipped PC.
- flush with redirect_pc=32'h100 while rvalid=1: that rdata is discarded; valid_out=0 next cycle; next imem_addr=32'h100.
- 3-cycle memory, flush with redirect_pc=32'h200 one cycle after request: FSM enters DROP; stale response is discarded; next request has imem_addr=32'h200; no instruction from the old PC reaches valid_out.
- stall and flush together: flush wins; valid_out=0, ir_out=32'h0000_0013; buffer empty.
- rstn pulsed low mid-WAIT: outputs return to reset values immediately; fetch restarts at RESET_PC. With IF_PERF_CNT_EN defined, fetch_cnt=0 after reset and equals the number of delivered instructions afterwards.
